// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM-stage memory access controller:
// FSM encoding, byte-enable patterns and timeout default.
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;

    localparam int TIMEOUT_DEFAULT = 255;

    function automatic logic is_misaligned(
        input logic       w_h,
        input logic [1:0] lo
    );
        return w_h ? lo[0] : (lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering for stores and lane extraction with sign extension
// for loads; purely combinational.
module mem_align
    import pipeline_pkg::*;
(
    input  logic        w_h,
    input  logic [1:0]  dir,
    input  logic [31:0] di,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic [31:0] load_val,
    output logic        misaligned
);

    logic [15:0] half;

    always_comb begin
        half       = dir[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        misaligned = is_misaligned(w_h, dir);
        if (w_h) begin
            mem_wdata = {di[15:0], di[15:0]};
            mem_be    = dir[1] ? BE_HALF_HI : BE_HALF_LO;
            load_val  = {{16{half[15]}}, half};
        end else begin
            mem_wdata = di;
            mem_be    = BE_WORD;
            load_val  = mem_rdata;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues one registered memory request per
// load/store, stalls the pipeline while it is outstanding.
module mem_access_ctrl
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        reloj,
    input  logic        reset_n,
    input  logic        MEM_RD,
    input  logic        MEM_WR,
    input  logic        w_h,
    input  logic [31:0] DIR,
    input  logic [31:0] DI,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic [31:0] DO,
    output logic        mem_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic        wh_q;
    logic        lo_q;
    logic        req_in;
    logic        al_wh;
    logic [1:0]  al_dir;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic [3:0]  al_be;
    logic        mis;

    assign req_in = MEM_RD | MEM_WR;

    // In REQ the aligner decodes the latched size/lane, not live inputs
    assign al_wh  = (state == IDLE) ? w_h : wh_q;
    assign al_dir = (state == IDLE) ? DIR[1:0] : {lo_q, 1'b0};

    mem_align u_align (
        .w_h        (al_wh),
        .dir        (al_dir),
        .di         (DI),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (al_wdata),
        .mem_be     (al_be),
        .load_val   (al_load),
        .misaligned (mis)
    );

    assign stall = reset_n
                 & (((state == IDLE) & req_in & ~mis)
                 | (state == REQ));

    always_ff @(posedge reloj or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            wh_q      <= 1'b0;
            lo_q      <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'h0;
            DO        <= 32'h0;
            mem_err   <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_in && mis) begin
                        mem_err <= 1'b1;
                    end else if (req_in) begin
                        state     <= REQ;
                        cnt       <= 8'd0;
                        wh_q      <= w_h;
                        lo_q      <= DIR[1];
                        mem_req   <= 1'b1;
                        mem_we    <= MEM_WR;
                        mem_addr  <= {DIR[31:2], 2'b00};
                        mem_wdata <= al_wdata;
                        mem_be    <= al_be;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_we) DO <= al_load;
                    end else if (cnt == CNT_LAST) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        DO      <= 32'h0;
                        mem_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl with a transaction-level
// reference model and a per-cycle output comparator.
module tb_mem_access_ctrl;

    localparam int TMO = 4;

    logic        reloj = 1'b0;
    logic        reset_n = 1'b0;
    logic        MEM_RD = 1'b0;
    logic        MEM_WR = 1'b0;
    logic        w_h = 1'b0;
    logic [31:0] DIR = 32'h0;
    logic [31:0] DI = 32'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        stall;
    logic [31:0] DO;
    logic        mem_err;

    mem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .reloj     (reloj),
        .reset_n   (reset_n),
        .MEM_RD    (MEM_RD),
        .MEM_WR    (MEM_WR),
        .w_h       (w_h),
        .DIR       (DIR),
        .DI        (DI),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .DO        (DO),
        .mem_err   (mem_err)
    );

    always #5 reloj = ~reloj;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    logic        exp_stall = 1'b0;
    logic        exp_req = 1'b0;
    logic        exp_we = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_addr = 32'h0;
    logic [31:0] exp_wdata = 32'h0;
    logic [3:0]  exp_be = 4'h0;
    logic [31:0] model_do = 32'h0;

    logic [31:0] cap_addr = 32'h0;
    logic [31:0] cap_wdata = 32'h0;
    logic [3:0]  cap_be = 4'h0;
    logic        cap_we = 1'b0;

    int   stall_hi = 0;
    int   req_rises = 0;
    int   req_cyc = 0;
    int   err_pulses = 0;
    logic prev_req = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    function automatic logic bad_align(input logic wh, input logic [31:0] a);
        return wh ? (a % 2 != 0) : (a % 4 != 0);
    endfunction

    function automatic logic [31:0] steer(input logic wh, input logic [31:0] d);
        return wh ? {d[15:0], d[15:0]} : d;
    endfunction

    function automatic logic [3:0] lanes(input logic wh, input logic [31:0] a);
        if (!wh) return 4'hF;
        return (a % 4 >= 2) ? 4'hC : 4'h3;
    endfunction

    function automatic logic [31:0] extract(input logic wh,
                                            input logic [31:0] a,
                                            input logic [31:0] rd);
        logic [31:0] h;
        if (!wh) return rd;
        h = (a % 4 >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
        return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
    endfunction

    always @(negedge reloj) begin
        if (chk_en) begin
            check("stall", {31'b0, stall}, {31'b0, exp_stall});
            check("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
            check("mem_err", {31'b0, mem_err}, {31'b0, exp_err});
            check("DO", DO, model_do);
            if (exp_req) begin
                check("mem_we", {31'b0, mem_we}, {31'b0, exp_we});
                check("mem_addr", mem_addr, exp_addr);
                check("mem_wdata", mem_wdata, exp_wdata);
                check("mem_be", {28'b0, mem_be}, {28'b0, exp_be});
            end
            if (stall) stall_hi++;
            if (mem_req) req_cyc++;
            if (mem_req && !prev_req) req_rises++;
            if (mem_err) err_pulses++;
        end
        prev_req <= mem_req;
    end

    task automatic idle_cycle(input bit ack);
        @(posedge reloj); #1;
        MEM_RD = 1'b0;
        MEM_WR = 1'b0;
        DIR = $urandom;
        DI = $urandom;
        mem_ack = ack;
        mem_rdata = $urandom;
        exp_stall = 1'b0;
        exp_req = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic access(input bit rd, input bit wr, input bit wh,
                          input logic [31:0] a, input logic [31:0] d,
                          input int lat, input logic [31:0] rdat);
        bit acked;
        @(posedge reloj); #1;
        MEM_RD = rd;
        MEM_WR = wr;
        w_h = wh;
        DIR = a;
        DI = d;
        mem_ack = 1'($urandom % 2);
        mem_rdata = $urandom;
        exp_req = 1'b0;
        exp_err = 1'b0;
        if (bad_align(wh, a)) begin
            exp_stall = 1'b0;
            @(posedge reloj); #1;
            MEM_RD = 1'b0;
            MEM_WR = 1'b0;
            mem_ack = 1'($urandom % 2);
            exp_err = 1'b1;
        end else begin
            exp_stall = 1'b1;
            acked = 1'b0;
            for (int i = 0; i < TMO; i++) begin
                @(posedge reloj); #1;
                exp_req = 1'b1;
                exp_we = wr;
                exp_addr = a - (a % 4);
                exp_wdata = steer(wh, d);
                exp_be = lanes(wh, a);
                exp_stall = 1'b1;
                exp_err = 1'b0;
                cap_addr = mem_addr;
                cap_wdata = mem_wdata;
                cap_be = mem_be;
                cap_we = mem_we;
                mem_ack = (i == lat);
                mem_rdata = (i == lat) ? rdat : $urandom;
                if (i == lat) begin
                    acked = 1'b1;
                    break;
                end
            end
            @(posedge reloj); #1;
            exp_req = 1'b0;
            exp_stall = 1'b0;
            mem_ack = 1'($urandom % 2);
            mem_rdata = $urandom;
            if (acked) begin
                if (!wr) model_do = extract(wh, a, rdat);
            end else begin
                model_do = 32'h0;
                exp_err = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int r0;
        int q0;
        int e0;
        logic [31:0] a;
        bit rd;
        bit wr;
        int sel;

        MEM_RD = 1'b1;
        DIR = 32'h10;
        #2;
        check("rst_req", {31'b0, mem_req}, 32'h0);
        check("rst_we", {31'b0, mem_we}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_be", {28'b0, mem_be}, 32'h0);
        check("rst_do", DO, 32'h0);
        check("rst_err", {31'b0, mem_err}, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        @(posedge reloj);
        @(posedge reloj); #1;
        check("rst_hold_req", {31'b0, mem_req}, 32'h0);
        MEM_RD = 1'b0;
        reset_n = 1'b1;
        exp_stall = 1'b0;
        exp_req = 1'b0;
        exp_err = 1'b0;
        model_do = 32'h0;
        chk_en = 1'b1;

        s0 = stall_hi;
        access(1, 0, 0, 32'h10, $urandom, 0, 32'hDEAD_BEEF);
        @(negedge reloj); #1;
        check("t40_stall_cycles", 32'(stall_hi - s0), 32'd2);
        check("t40_addr", cap_addr, 32'h10);
        check("t40_do", DO, 32'hDEAD_BEEF);

        access(0, 1, 1, 32'h6, 32'h1234_ABCD, 1, $urandom);
        @(negedge reloj); #1;
        check("t41_be", {28'b0, cap_be}, 32'hC);
        check("t41_wdata", cap_wdata, 32'hABCD_ABCD);
        check("t41_we", {31'b0, cap_we}, 32'h1);
        check("t41_do_kept", DO, 32'hDEAD_BEEF);

        access(1, 0, 1, 32'h2, $urandom, 0, 32'h8001_0000);
        @(negedge reloj); #1;
        check("t42_do", DO, 32'hFFFF_8001);

        r0 = req_rises;
        e0 = err_pulses;
        access(1, 0, 0, 32'h3, $urandom, 0, $urandom);
        check("t43_err", {31'b0, mem_err}, 32'h1);
        idle_cycle(0);
        idle_cycle(0);
        @(negedge reloj); #1;
        check("t43_no_req", 32'(req_rises - r0), 32'd0);
        check("t43_one_err", 32'(err_pulses - e0), 32'd1);

        q0 = req_cyc;
        e0 = err_pulses;
        access(1, 0, 0, 32'h20, $urandom, 10, $urandom);
        idle_cycle(1);
        idle_cycle(1);
        @(negedge reloj); #1;
        check("t44_req_cycles", 32'(req_cyc - q0), 32'd4);
        check("t44_one_err", 32'(err_pulses - e0), 32'd1);
        check("t44_do", DO, 32'h0);

        @(posedge reloj); #1;
        MEM_RD = 1'b1;
        MEM_WR = 1'b0;
        w_h = 1'b0;
        DIR = 32'h40;
        mem_ack = 1'b0;
        exp_stall = 1'b1;
        exp_req = 1'b0;
        exp_err = 1'b0;
        @(posedge reloj); #1;
        exp_req = 1'b1;
        exp_we = 1'b0;
        exp_addr = 32'h40;
        exp_wdata = DI;
        exp_be = 4'hF;
        #2;
        chk_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check("t45_req_async", {31'b0, mem_req}, 32'h0);
        check("t45_stall", {31'b0, stall}, 32'h0);
        check("t45_do", DO, 32'h0);
        @(posedge reloj); #1;
        MEM_RD = 1'b0;
        reset_n = 1'b1;
        model_do = 32'h0;
        exp_stall = 1'b0;
        exp_req = 1'b0;
        exp_err = 1'b0;
        chk_en = 1'b1;
        r0 = req_rises;
        q0 = req_cyc;
        access(1, 0, 0, 32'h44, $urandom, 0, $urandom);
        access(1, 0, 1, 32'h4A, $urandom, 1, $urandom);
        @(negedge reloj); #1;
        check("t45_two_reqs", 32'(req_rises - r0), 32'd2);
        check("t45_req_cycles", 32'(req_cyc - q0), 32'd3);

        for (int k = 0; k < 300; k++) begin
            if ($urandom % 8 == 0) begin
                idle_cycle(1'($urandom % 2));
            end else begin
                sel = int'($urandom % 3);
                rd = (sel != 1);
                wr = (sel != 0);
                a = $urandom;
                if ($urandom % 4 != 0) a = a & 32'hFFFF_FFFC;
                access(rd, wr, 1'($urandom % 2), a, $urandom,
                       int'($urandom_range(0, 5)), $urandom);
            end
        end

        idle_cycle(0);
        @(negedge reloj); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles in REQ awaiting mem_ack before abort; legal range 1..255.
REQ-002 reloj  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 MEM_RD  input  1  MEM-stage load request, from the EX/MEM pipeline register.
REQ-005 MEM_WR  input  1  MEM-stage store request, from the EX/MEM pipeline register.
REQ-006 w_h  input  1  access size; 0 = word, 1 = halfword.
REQ-007 DIR  input  32  byte address of the access.
REQ-008 DI  input  32  store data.
REQ-009 mem_req  output  1  memory request, registered.
REQ-010 mem_we  output  1  write enable, valid while mem_req=1.
REQ-011 mem_addr  output  32  word address, {DIR[31:2],2'b00}, registered.
REQ-012 mem_wdata  output  32  lane-aligned store data, registered.
REQ-013 mem_be  output  4  byte enables, registered.
REQ-014 mem_ack  input  1  memory completion, sampled only in REQ.
REQ-015 mem_rdata  input  32  read data, valid when mem_ack=1.
REQ-016 stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM registers; combinational.
REQ-017 DO  output  32  load result to MEM/WB, registered.
REQ-018 mem_err  output  1  one-cycle pulse on misaligned access or timeout.

Function
REQ-019 FSM states: IDLE, REQ and DONE; state encoding lives in the shared package.
REQ-020 A request exists when MEM_RD|MEM_WR=1; when both are 1, the store SHALL win (mem_we=1).
REQ-021 An access is misaligned when w_h=0 and DIR[1:0]!=0, or when w_h=1 and DIR[0]=1.
REQ-022 IDLE, aligned request: stall=1 the same cycle; next edge -> REQ, loading mem_req=1, mem_we, mem_addr, mem_wdata, mem_be and clearing the timeout counter.
REQ-023 IDLE, misaligned request: no memory access and stall=0; next edge -> mem_err=1 for one cycle; state stays IDLE.
REQ-024 REQ: stall=1; mem_req, mem_addr, mem_wdata, mem_be and mem_we SHALL be held stable until exit; the counter increments each cycle without mem_ack.
REQ-025 REQ with mem_ack=1: next edge -> DONE and mem_req=0; on a load, DO gets the extracted mem_rdata.
REQ-026 REQ when the counter reaches TIMEOUT-1 with no mem_ack: next edge -> DONE, mem_req=0, DO=0, mem_err pulse.
REQ-027 DONE: stall=0 and DO is valid; next edge -> IDLE unconditionally, so a held request is never reissued.
REQ-028 Minimum latency with an immediate ack: stall high 2 cycles (IDLE + REQ), DO valid on the 3rd cycle.
REQ-029 Word store: mem_be=4'b1111 and mem_wdata=DI.
REQ-030 Halfword store: mem_wdata={DI[15:0],DI[15:0]}; mem_be=4'b0011 when DIR[1]=0, 4'b1100 when DIR[1]=1.
REQ-031 Word load: DO=mem_rdata.
REQ-032 Halfword load: sign-extend mem_rdata[15:0] when DIR[1]=0, or mem_rdata[31:16] when DIR[1]=1.
REQ-033 A store SHALL leave DO unchanged.
REQ-034 A mem_ack outside REQ SHALL be ignored.

Reset
REQ-035 reset_n=0 SHALL immediately force: state IDLE; mem_req, mem_we, mem_err and the counter 0; mem_addr, mem_wdata and DO 32'h0; mem_be 4'h0.
REQ-036 Reset during REQ SHALL drop mem_req asynchronously; the aborted access is not retried.
REQ-037 stall SHALL be 0 while reset_n=0.

Structure
REQ-038 FSM state encodings, byte-enable constants and the TIMEOUT default belong in the shared package pipeline_pkg.
REQ-039 Lane steering and extension SHALL live in the combinational sub-module mem_align, with inputs w_h, DIR[1:0], DI and mem_rdata and outputs mem_wdata, mem_be and the extracted load value.

Verification
REQ-040 Word load: MEM_RD=1, DIR=32'h0000_0010, ack on the first REQ cycle, mem_rdata=32'hDEAD_BEEF -> stall high 2 cycles, mem_addr=32'h10, DO=32'hDEAD_BEEF in DONE.
REQ-041 Halfword store: MEM_WR=1, w_h=1, DIR=32'h0000_0006, DI=32'h1234_ABCD -> mem_be=4'b1100, mem_wdata=32'hABCD_ABCD, mem_we=1.
REQ-042 Halfword load: w_h=1, DIR=32'h0000_0002, mem_rdata=32'h8001_0000 -> DO=32'hFFFF_8001.
REQ-043 Misaligned word load: DIR=32'h0000_0003 -> mem_req never rises, stall=0, mem_err pulses once.
REQ-044 Timeout: TIMEOUT=4, mem_ack held 0 -> exactly 4 REQ cycles, then DO=0 and mem_err pulse; a late mem_ack is ignored.
REQ-045 Reset mid-REQ, then back-to-back loads: reset_n=0 during REQ -> mem_req=0 without a clock edge; two back-to-back loads each issue exactly one mem_req.
